tt_um_emern_frontend_spec: RTL and testbench

TT_UM_EMERN_FRONTEND_SPEC -- requirements
Module: tt_um_emern_frontend

---
 rtl/tt_um_emern_frontend_spec_pkg.sv | 80 ++++++++
 rtl/tt_um_emern_frontend_spec_spi_rx.sv | 100 ++++++++++
 rtl/tt_um_emern_frontend_spec.sv | 94 +++++++++
 tb/tb_tt_um_emern_frontend_spec.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_emern_frontend_spec_pkg.sv
// Shared widths, register map and shadow-register layout for the polygon frontend.
package tt_um_emern_frontend_spec_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BIT_CNT_W  = 3;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned COLOR_W    = 6;
    localparam int unsigned X_W        = 7;
    localparam int unsigned Y_W        = 6;
    localparam int unsigned DEPTH_W    = 3;
    localparam int unsigned NUM_POLY   = 2;
    localparam int unsigned POLY_IDX_W = 1;

    localparam logic [ADDR_W-1:0] ADDR_BG        = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_SCREEN = 7'h01;
    localparam logic [ADDR_W-1:0] POLY0_BASE     = 7'h10;
    localparam logic [ADDR_W-1:0] POLY1_BASE     = 7'h20;

    localparam logic [ADDR_W-1:0] OFF_COLOR  = 7'd0;
    localparam logic [ADDR_W-1:0] OFF_V0_X   = 7'd1;
    localparam logic [ADDR_W-1:0] OFF_V0_Y   = 7'd2;
    localparam logic [ADDR_W-1:0] OFF_V1_X   = 7'd3;
    localparam logic [ADDR_W-1:0] OFF_V1_Y   = 7'd4;
    localparam logic [ADDR_W-1:0] OFF_V2_X   = 7'd5;
    localparam logic [ADDR_W-1:0] OFF_V2_Y   = 7'd6;
    localparam logic [ADDR_W-1:0] OFF_DEPTH  = 7'd7;
    localparam logic [ADDR_W-1:0] OFF_ENABLE = 7'd8;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [X_W-1:0]     v0_x;
        logic [Y_W-1:0]     v0_y;
        logic [X_W-1:0]     v1_x;
        logic [Y_W-1:0]     v1_y;
        logic [X_W-1:0]     v2_x;
        logic [Y_W-1:0]     v2_y;
        logic [DEPTH_W-1:0] depth;
        logic               enable;
    } poly_regs_t;

    typedef struct packed {
        logic [COLOR_W-1:0]            bg_color;
        logic                          en_screen;
        poly_regs_t [NUM_POLY-1:0]     poly;
    } frame_regs_t;

    function automatic logic [ADDR_W-1:0] poly_base(input logic [POLY_IDX_W-1:0] idx);
        return (idx == POLY_IDX_W'(0)) ? POLY0_BASE : POLY1_BASE;
    endfunction

    // Apply one data byte to the register image; unmapped addresses leave it untouched.
    function automatic frame_regs_t reg_write(input frame_regs_t cur,
                                             input logic [ADDR_W-1:0] addr,
                                             input logic [BYTE_W-1:0] data);
        frame_regs_t               nxt;
        logic [ADDR_W-1:0]         off;
        logic [POLY_IDX_W-1:0]     idx;
        nxt = cur;
        if (addr == ADDR_BG)        nxt.bg_color  = data[COLOR_W-1:0];
        if (addr == ADDR_EN_SCREEN) nxt.en_screen = data[0];
        for (int unsigned p = 0; p < NUM_POLY; p++) begin
            idx = POLY_IDX_W'(p);
            off = addr - poly_base(idx);
            case (off)
                OFF_COLOR:  nxt.poly[idx].color  = data[COLOR_W-1:0];
                OFF_V0_X:   nxt.poly[idx].v0_x   = data[X_W-1:0];
                OFF_V0_Y:   nxt.poly[idx].v0_y   = data[Y_W-1:0];
                OFF_V1_X:   nxt.poly[idx].v1_x   = data[X_W-1:0];
                OFF_V1_Y:   nxt.poly[idx].v1_y   = data[Y_W-1:0];
                OFF_V2_X:   nxt.poly[idx].v2_x   = data[X_W-1:0];
                OFF_V2_Y:   nxt.poly[idx].v2_y   = data[Y_W-1:0];
                OFF_DEPTH:  nxt.poly[idx].depth  = data[DEPTH_W-1:0];
                OFF_ENABLE: nxt.poly[idx].enable = data[0];
                default: ;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tt_um_emern_frontend_spec_spi_rx.sv
// SPI mode-0 receiver: input synchronisers, sck edge detect and byte deserialiser.
module tt_um_emern_frontend_spec_spi_rx
    import tt_um_emern_frontend_spec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_in,
    input  logic              mosi_in,
    input  logic              sck_in,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              first_byte
);

    logic                 cs_meta_q,   cs_meta_d;
    logic                 cs_sync_q,   cs_sync_d;
    logic                 sck_meta_q,  sck_meta_d;
    logic                 sck_sync_q,  sck_sync_d;
    logic                 sck_prev_q,  sck_prev_d;
    logic                 mosi_meta_q, mosi_meta_d;
    logic                 mosi_sync_q, mosi_sync_d;
    logic                 armed_q,     armed_d;
    logic                 data_phase_q, data_phase_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [BYTE_W-1:0]    shift_q,     shift_d;
    logic                 valid_q,     valid_d;
    logic                 first_q,     first_d;
    logic                 sck_rise;

    assign sck_rise = sck_sync_q & ~sck_prev_q;

    // Receiver only listens after it has seen cs deasserted since the last reset.
    always_comb begin
        cs_meta_d    = cs_in;
        cs_sync_d    = cs_meta_q;
        sck_meta_d   = sck_in;
        sck_sync_d   = sck_meta_q;
        sck_prev_d   = sck_sync_q;
        mosi_meta_d  = mosi_in;
        mosi_sync_d  = mosi_meta_q;
        armed_d      = armed_q;
        data_phase_d = data_phase_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        valid_d      = 1'b0;
        first_d      = 1'b0;

        if (cs_sync_q) begin
            armed_d      = 1'b1;
            bit_cnt_d    = '0;
            shift_d      = '0;
            data_phase_d = 1'b0;
        end else if (armed_q && sck_rise) begin
            shift_d   = {shift_q[BYTE_W-2:0], mosi_sync_q};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
                valid_d      = 1'b1;
                first_d      = ~data_phase_q;
                data_phase_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cs_meta_q    <= 1'b0;
            cs_sync_q    <= 1'b0;
            sck_meta_q   <= 1'b0;
            sck_sync_q   <= 1'b0;
            sck_prev_q   <= 1'b0;
            mosi_meta_q  <= 1'b0;
            mosi_sync_q  <= 1'b0;
            armed_q      <= 1'b0;
            data_phase_q <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
        end else begin
            cs_meta_q    <= cs_meta_d;
            cs_sync_q    <= cs_sync_d;
            sck_meta_q   <= sck_meta_d;
            sck_sync_q   <= sck_sync_d;
            sck_prev_q   <= sck_prev_d;
            mosi_meta_q  <= mosi_meta_d;
            mosi_sync_q  <= mosi_sync_d;
            armed_q      <= armed_d;
            data_phase_q <= data_phase_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            valid_q      <= valid_d;
            first_q      <= first_d;
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign first_byte = first_q;

endmodule

// File: rtl/tt_um_emern_frontend_spec.sv
// Polygon frontend: SPI-written shadow registers copied to registered outputs on en_load.
module tt_um_emern_frontend_spec
    import tt_um_emern_frontend_spec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_in,
    input  logic        mosi_in,
    input  logic        miso_in,
    input  logic        sck_in,
    input  logic        en_load,
    output logic [5:0]  bg_color_out,
    output logic [11:0] poly_color_out,
    output logic [13:0] v0_x_out,
    output logic [13:0] v1_x_out,
    output logic [13:0] v2_x_out,
    output logic [11:0] v0_y_out,
    output logic [11:0] v1_y_out,
    output logic [11:0] v2_y_out,
    output logic [5:0]  poly_depth_out,
    output logic        en_screen_out,
    output logic [1:0]  poly_enable_out
);

    logic              rx_valid;
    logic [BYTE_W-1:0] rx_byte;
    logic              rx_first;
    logic              unused_miso;

    frame_regs_t       shadow_q, shadow_d;
    frame_regs_t       out_q,    out_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;

    assign unused_miso = miso_in;

    tt_um_emern_frontend_spec_spi_rx u_spi_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_in      (cs_in),
        .mosi_in    (mosi_in),
        .sck_in     (sck_in),
        .byte_valid (rx_valid),
        .byte_data  (rx_byte),
        .first_byte (rx_first)
    );

    // First byte of a transaction loads the address; later bytes write and auto-increment.
    always_comb begin
        shadow_d = shadow_q;
        addr_d   = addr_q;
        if (rx_valid) begin
            if (rx_first) begin
                addr_d = rx_byte[ADDR_W-1:0];
            end else begin
                shadow_d = reg_write(shadow_q, addr_q, rx_byte);
                addr_d   = addr_q + ADDR_W'(1);
            end
        end
    end

    // Outputs sample the pre-write shadow image, so a coincident write lands on the next load.
    always_comb begin
        out_d = out_q;
        if (en_load) out_d = shadow_q;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            shadow_q <= '0;
            out_q    <= '0;
            addr_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            out_q    <= out_d;
            addr_q   <= addr_d;
        end
    end

    assign bg_color_out  = out_q.bg_color;
    assign en_screen_out = out_q.en_screen;

    for (genvar p = 0; p < NUM_POLY; p++) begin : g_poly_out
        assign poly_color_out[p*COLOR_W +: COLOR_W] = out_q.poly[p].color;
        assign v0_x_out[p*X_W +: X_W]               = out_q.poly[p].v0_x;
        assign v1_x_out[p*X_W +: X_W]               = out_q.poly[p].v1_x;
        assign v2_x_out[p*X_W +: X_W]               = out_q.poly[p].v2_x;
        assign v0_y_out[p*Y_W +: Y_W]               = out_q.poly[p].v0_y;
        assign v1_y_out[p*Y_W +: Y_W]               = out_q.poly[p].v1_y;
        assign v2_y_out[p*Y_W +: Y_W]               = out_q.poly[p].v2_y;
        assign poly_depth_out[p*DEPTH_W +: DEPTH_W] = out_q.poly[p].depth;
        assign poly_enable_out[p]                   = out_q.poly[p].enable;
    end

endmodule

// File: tb/tb_tt_um_emern_frontend_spec.sv
// Scoreboard bench: stimulus queues expected output images, a monitor compares on each probe.
module tb_tt_um_emern_frontend_spec;

    typedef struct packed {
        logic [5:0]  bg;
        logic [11:0] pc;
        logic [13:0] v0x;
        logic [13:0] v1x;
        logic [13:0] v2x;
        logic [11:0] v0y;
        logic [11:0] v1y;
        logic [11:0] v2y;
        logic [5:0]  depth;
        logic        ens;
        logic [1:0]  pen;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        cs_in;
    logic        mosi_in;
    logic        miso_in;
    logic        sck_in;
    logic        en_load;
    logic [5:0]  bg_color_out;
    logic [11:0] poly_color_out;
    logic [13:0] v0_x_out;
    logic [13:0] v1_x_out;
    logic [13:0] v2_x_out;
    logic [11:0] v0_y_out;
    logic [11:0] v1_y_out;
    logic [11:0] v2_y_out;
    logic [5:0]  poly_depth_out;
    logic        en_screen_out;
    logic [1:0]  poly_enable_out;

    logic        probe;
    exp_t        exp_m;
    exp_t        mon_e;
    exp_t        exp_q[$];
    int          n_checks;
    int          n_pass;

    tt_um_emern_frontend_spec dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cs_in           (cs_in),
        .mosi_in         (mosi_in),
        .miso_in         (miso_in),
        .sck_in          (sck_in),
        .en_load         (en_load),
        .bg_color_out    (bg_color_out),
        .poly_color_out  (poly_color_out),
        .v0_x_out        (v0_x_out),
        .v1_x_out        (v1_x_out),
        .v2_x_out        (v2_x_out),
        .v0_y_out        (v0_y_out),
        .v1_y_out        (v1_y_out),
        .v2_y_out        (v2_y_out),
        .poly_depth_out  (poly_depth_out),
        .en_screen_out   (en_screen_out),
        .poly_enable_out (poly_enable_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: whenever a probe is raised, pop the next expected image and compare every output.
    always @(posedge clk) begin
        if (probe) begin
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty: got probe expected queued image");
            end else begin
                mon_e = exp_q.pop_front();
                chk("bg_color",    14'(bg_color_out),    14'(mon_e.bg));
                chk("poly_color",  14'(poly_color_out),  14'(mon_e.pc));
                chk("v0_x",        v0_x_out,             mon_e.v0x);
                chk("v1_x",        v1_x_out,             mon_e.v1x);
                chk("v2_x",        v2_x_out,             mon_e.v2x);
                chk("v0_y",        14'(v0_y_out),        14'(mon_e.v0y));
                chk("v1_y",        14'(v1_y_out),        14'(mon_e.v1y));
                chk("v2_y",        14'(v2_y_out),        14'(mon_e.v2y));
                chk("poly_depth",  14'(poly_depth_out),  14'(mon_e.depth));
                chk("en_screen",   14'(en_screen_out),   14'(mon_e.ens));
                chk("poly_enable", 14'(poly_enable_out), 14'(mon_e.pen));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi_in = b[i];
            cyc(4);
            sck_in = 1'b1;
            cyc(4);
            sck_in = 1'b0;
        end
    endtask

    task automatic spi_begin();
        cs_in = 1'b0;
        cyc(4);
    endtask

    task automatic spi_end();
        cyc(4);
        cs_in = 1'b1;
        cyc(12);
    endtask

    task automatic probe_push();
        exp_q.push_back(exp_m);
        probe = 1'b1;
        cyc(1);
        probe = 1'b0;
        cyc(2);
    endtask

    task automatic load_check();
        en_load = 1'b1;
        cyc(1);
        en_load = 1'b0;
        probe_push();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b1;
        cs_in    = 1'b1;
        sck_in   = 1'b0;
        mosi_in  = 1'b0;
        miso_in  = 1'b0;
        en_load  = 1'b0;
        probe    = 1'b0;
        exp_m    = '0;
        cyc(2);
        rst_n = 1'b0;
        cyc(4);

        // Reset image
        probe_push();

        // Background colour, visible only after load
        spi_begin(); spi_bits(8'h00, 8); spi_bits(8'h2A, 8); spi_end();
        probe_push();
        exp_m.bg = 6'h2A;
        load_check();

        // Burst into poly0 vertices
        spi_begin(); spi_bits(8'h11, 8); spi_bits(8'h55, 8); spi_bits(8'h20, 8); spi_bits(8'h7F, 8); spi_end();
        exp_m.v0x[6:0] = 7'h55;
        exp_m.v0y[5:0] = 6'h20;
        exp_m.v1x[6:0] = 7'h7F;
        load_check();

        // Poly1 enable and screen enable
        spi_begin(); spi_bits(8'h28, 8); spi_bits(8'h01, 8); spi_end();
        spi_begin(); spi_bits(8'h01, 8); spi_bits(8'h01, 8); spi_end();
        exp_m.pen = 2'b10;
        exp_m.ens = 1'b1;
        load_check();

        // Poly1 depth, then an aborted write to the same register
        spi_begin(); spi_bits(8'h27, 8); spi_bits(8'h05, 8); spi_end();
        exp_m.depth[5:3] = 3'd5;
        load_check();
        spi_begin(); spi_bits(8'h27, 8); spi_bits(8'hFF, 5); spi_end();
        load_check();

        // Unmapped address skipped, truncation, bit7 of address ignored, 0x7F wrap
        spi_begin(); spi_bits(8'h1F, 8); spi_bits(8'h11, 8); spi_bits(8'h15, 8); spi_bits(8'hC6, 8); spi_end();
        exp_m.pc[11:6]   = 6'h15;
        exp_m.v0x[13:7]  = 7'h46;
        spi_begin(); spi_bits(8'h97, 8); spi_bits(8'hFE, 8); spi_bits(8'h03, 8); spi_end();
        exp_m.depth[2:0] = 3'd6;
        exp_m.pen[0]     = 1'b1;
        spi_begin(); spi_bits(8'h7F, 8); spi_bits(8'h99, 8); spi_bits(8'h0C, 8); spi_end();
        exp_m.bg = 6'h0C;
        load_check();

        // Continuous load while writing poly0 colour
        en_load = 1'b1;
        cyc(2);
        spi_begin(); spi_bits(8'h10, 8); spi_bits(8'h3F, 8); spi_end();
        exp_m.pc[5:0] = 6'h3F;
        probe_push();
        en_load = 1'b0;
        cyc(2);

        // Reset mid-transaction; traffic ignored until cs toggles high then low
        spi_begin(); spi_bits(8'h00, 8); spi_bits(8'h3F, 3);
        rst_n = 1'b1;
        cyc(2);
        rst_n = 1'b0;
        cyc(2);
        spi_bits(8'h00, 8); spi_bits(8'h3F, 8); spi_bits(8'h01, 8);
        cyc(8);
        exp_m = '0;
        load_check();
        cs_in = 1'b1;
        cyc(12);
        spi_begin(); spi_bits(8'h00, 8); spi_bits(8'h21, 8); spi_end();
        exp_m.bg = 6'h21;
        load_check();

        cyc(4);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
